// File: rtl/ecc_apb_driver.sv
// Command-to-APB sequencer for the ECC block: programs DATA_IN, CODEWORD_WIDTH,
// NOISE and CTRL, waits for operation_done (bounded) and returns one response.
module ecc_apb_driver #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int DATA_WIDTH      = 32,
    parameter int TIMEOUT         = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_ctrl,
    input  logic [DATA_WIDTH-1:0]      cmd_data,
    input  logic [1:0]                 cmd_width,
    input  logic [DATA_WIDTH-1:0]      cmd_noise,
    output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
    output logic                       PSEL,
    output logic                       PENABLE,
    output logic                       PWRITE,
    output logic [AMBA_WORD-1:0]       PWDATA,
    input  logic [DATA_WIDTH-1:0]      data_out,
    input  logic                       operation_done,
    input  logic [1:0]                 num_of_errors,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [1:0]                 rsp_errors,
    output logic                       rsp_timeout,
    output logic                       rsp_illegal
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CTRL    = AMBA_ADDR_WIDTH'(8'h00);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_DATA_IN = AMBA_ADDR_WIDTH'(8'h04);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_CW_W    = AMBA_ADDR_WIDTH'(8'h08);
    localparam logic [AMBA_ADDR_WIDTH-1:0] ADDR_NOISE   = AMBA_ADDR_WIDTH'(8'h0C);

    localparam logic [1:0] CTRL_ILLEGAL = 2'd3;
    localparam logic [1:0] IDX_LAST     = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    typedef struct packed {
        logic [1:0]            ctrl;
        logic [DATA_WIDTH-1:0] data;
        logic [1:0]            width;
        logic [DATA_WIDTH-1:0] noise;
    } cmd_t;

    state_t                state, state_d;
    cmd_t                  cmd_q;
    logic [1:0]            idx;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic [1:0]            rsp_errors_q;
    logic                  rsp_timeout_q;
    logic                  rsp_illegal_q;

    logic [AMBA_WORD-1:0]  data_w;
    logic [AMBA_WORD-1:0]  noise_w;
    logic [AMBA_WORD-1:0]  width_w;
    logic [AMBA_WORD-1:0]  ctrl_w;

    // ECC data and APB words may differ in width: truncate or zero-extend.
    generate
        if (DATA_WIDTH >= AMBA_WORD) begin : g_trunc
            assign data_w  = cmd_q.data[AMBA_WORD-1:0];
            assign noise_w = cmd_q.noise[AMBA_WORD-1:0];
        end else begin : g_zext
            assign data_w  = {{(AMBA_WORD-DATA_WIDTH){1'b0}}, cmd_q.data};
            assign noise_w = {{(AMBA_WORD-DATA_WIDTH){1'b0}}, cmd_q.noise};
        end
    endgenerate

    assign width_w = {{(AMBA_WORD-2){1'b0}}, cmd_q.width};
    assign ctrl_w  = {{(AMBA_WORD-2){1'b0}}, cmd_q.ctrl};

    always_comb begin
        state_d = state;
        case (state)
            IDLE:   if (cmd_valid) state_d = (cmd_ctrl == CTRL_ILLEGAL) ? RESP : SETUP;
            SETUP:  state_d = ACCESS;
            ACCESS: state_d = (idx == IDX_LAST) ? WAIT : SETUP;
            WAIT:   if (operation_done || cnt == CNT_LAST) state_d = RESP;
            RESP:   if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cmd_q         <= '0;
            idx           <= '0;
            cnt           <= '0;
            rsp_data_q    <= '0;
            rsp_errors_q  <= '0;
            rsp_timeout_q <= 1'b0;
            rsp_illegal_q <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cmd_q.ctrl    <= cmd_ctrl;
                        cmd_q.data    <= cmd_data;
                        cmd_q.width   <= cmd_width;
                        cmd_q.noise   <= cmd_noise;
                        idx           <= '0;
                        rsp_data_q    <= '0;
                        rsp_errors_q  <= '0;
                        rsp_timeout_q <= 1'b0;
                        rsp_illegal_q <= (cmd_ctrl == CTRL_ILLEGAL);
                    end
                end
                ACCESS: begin
                    if (idx == IDX_LAST) cnt <= '0;
                    else                 idx <= idx + 2'd1;
                end
                WAIT: begin
                    // A done pulse on the final count still wins over the timeout.
                    if (operation_done) begin
                        rsp_data_q   <= data_out;
                        rsp_errors_q <= num_of_errors;
                    end else if (cnt == CNT_LAST) begin
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        if (state == SETUP || state == ACCESS) begin
            PSEL    = 1'b1;
            PENABLE = (state == ACCESS);
            PWRITE  = 1'b1;
            case (idx)
                2'd0:    begin PADDR = ADDR_DATA_IN; PWDATA = data_w;  end
                2'd1:    begin PADDR = ADDR_CW_W;    PWDATA = width_w; end
                2'd2:    begin PADDR = ADDR_NOISE;   PWDATA = noise_w; end
                default: begin PADDR = ADDR_CTRL;    PWDATA = ctrl_w;  end
            endcase
        end
    end

    assign cmd_ready   = (state == IDLE);
    assign rsp_valid   = (state == RESP);
    assign rsp_data    = rsp_data_q;
    assign rsp_errors  = rsp_errors_q;
    assign rsp_timeout = rsp_timeout_q;
    assign rsp_illegal = rsp_illegal_q;

endmodule

// File: tb/tb_ecc_apb_driver.sv
// Bench for ecc_apb_driver: table vectors, random transactions against a
// cycle-schedule model, and reset / back-pressure sequences.
module tb_ecc_apb_driver;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_ctrl = '0;
    logic [31:0] cmd_data = '0;
    logic [1:0]  cmd_width = '0;
    logic [31:0] cmd_noise = '0;
    logic [19:0] PADDR;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] data_out = '0;
    logic        operation_done = 1'b0;
    logic [1:0]  num_of_errors = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_errors;
    logic        rsp_timeout, rsp_illegal;

    int n_vec = 0;
    int n_err = 0;

    ecc_apb_driver #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ctrl(cmd_ctrl),
        .cmd_data(cmd_data), .cmd_width(cmd_width), .cmd_noise(cmd_noise),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .data_out(data_out), .operation_done(operation_done), .num_of_errors(num_of_errors),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_errors(rsp_errors), .rsp_timeout(rsp_timeout), .rsp_illegal(rsp_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] data;
        logic [1:0]  width;
        logic [31:0] noise;
        int          done_off;   // cycles after WAIT entry; -1 = never
        logic [31:0] dout;
        logic [1:0]  nerr;
        int          rdy_dly;
        bit          resp_pulse;
        logic [31:0] exp_data;
        logic [1:0]  exp_err;
        logic        exp_to;
        logic        exp_ill;
        int          exp_cyc;    // cycle of first rsp_valid
    } vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: 8 write cycles, WAIT starts at cycle 9, response the cycle
    // after done is seen, or at 9+TIMEOUT if done never arrives in time.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.ctrl == 2'd3) begin
            r.exp_data = 0; r.exp_err = 0; r.exp_to = 0; r.exp_ill = 1; r.exp_cyc = 1;
        end else if (v.done_off >= 0 && v.done_off < TO - 1) begin
            r.exp_data = v.dout; r.exp_err = v.nerr; r.exp_to = 0; r.exp_ill = 0;
            r.exp_cyc = 10 + v.done_off;
        end else begin
            r.exp_data = 0; r.exp_err = 0; r.exp_to = 1; r.exp_ill = 0; r.exp_cyc = 9 + TO;
        end
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        logic [19:0] addr_tbl [4];
        logic [31:0] dat [4];
        logic [63:0] exp_apb;
        int idx;
        addr_tbl[0] = 20'h04; addr_tbl[1] = 20'h08; addr_tbl[2] = 20'h0C; addr_tbl[3] = 20'h00;
        dat[0] = v.data; dat[1] = {30'd0, v.width}; dat[2] = v.noise; dat[3] = {30'd0, v.ctrl};

        chk("idle_ready", {63'd0, cmd_ready}, 64'd1);
        cmd_valid = 1'b1; cmd_ctrl = v.ctrl; cmd_data = v.data;
        cmd_width = v.width; cmd_noise = v.noise;
        step();
        cmd_valid = 1'b0; cmd_ctrl = 2'($urandom); cmd_data = $urandom;
        cmd_width = 2'($urandom); cmd_noise = $urandom;

        for (int k = 1; k < v.exp_cyc; k++) begin
            if (v.ctrl != 2'd3 && k <= 8) begin
                idx = (k - 1) / 2;
                exp_apb = {9'd0, 1'b1, 1'(k % 2 == 0), 1'b1, addr_tbl[idx], dat[idx]};
            end else begin
                exp_apb = '0;
            end
            chk("apb", {9'd0, PSEL, PENABLE, PWRITE, PADDR, PWDATA}, exp_apb);
            chk("busy", {62'd0, rsp_valid, cmd_ready}, 64'd0);
            data_out = $urandom; num_of_errors = 2'($urandom);
            operation_done = (k == 4) || (v.done_off >= 0 && k == 9 + v.done_off);
            if (v.done_off >= 0 && k == 9 + v.done_off) begin
                data_out = v.dout; num_of_errors = v.nerr;
            end
            step();
        end
        operation_done = 1'b0;

        for (int r = 0; r <= v.rdy_dly; r++) begin
            chk("rsp", {27'd0, rsp_valid, rsp_data, rsp_errors, rsp_timeout, rsp_illegal},
                {27'd0, 1'b1, v.exp_data, v.exp_err, v.exp_to, v.exp_ill});
            chk("resp_quiet", {62'd0, cmd_ready, PSEL}, 64'd0);
            rsp_ready = (r == v.rdy_dly);
            operation_done = v.resp_pulse && (r == 2);
            data_out = ~v.exp_data; num_of_errors = ~v.exp_err;
            step();
        end
        rsp_ready = 1'b0; operation_done = 1'b0;
        chk("post_rsp", {62'd0, rsp_valid, cmd_ready}, 64'd1);
    endtask

    vec_t tbl [5];
    vec_t v;

    initial begin
        tbl[0] = '{2'd0, 32'h0000_00A5, 2'd0, 32'h0, 3, 32'h1A5, 2'd0, 0, 1'b0,
                   32'h1A5, 2'd0, 1'b0, 1'b0, 13};
        tbl[1] = '{2'd1, 32'h0000_01A5, 2'd1, 32'h1, 2, 32'hA5, 2'd1, 1, 1'b0,
                   32'hA5, 2'd1, 1'b0, 1'b0, 12};
        tbl[2] = '{2'd2, 32'h0000_1234, 2'd2, 32'h0, -1, 32'h0, 2'd0, 0, 1'b0,
                   32'h0, 2'd0, 1'b1, 1'b0, 25};
        tbl[3] = '{2'd3, 32'h0000_DEAD, 2'd3, 32'hFF, -1, 32'h0, 2'd0, 2, 1'b0,
                   32'h0, 2'd0, 1'b0, 1'b1, 1};
        tbl[4] = '{2'd0, 32'h0000_CAFE, 2'd1, 32'h0, 0, 32'h55, 2'd2, 10, 1'b1,
                   32'h55, 2'd2, 1'b0, 1'b0, 10};

        step(); step();
        rst = 1'b0;
        chk("reset_ctl", {57'd0, cmd_ready, PSEL, PENABLE, PWRITE, rsp_valid, rsp_timeout, rsp_illegal},
            64'h40);
        chk("reset_bus", {12'd0, PADDR, PWDATA}, 64'd0);
        chk("reset_rsp", {30'd0, rsp_data, rsp_errors}, 64'd0);

        foreach (tbl[i]) run_txn(tbl[i]);

        for (int n = 0; n < 30; n++) begin
            v.ctrl = 2'($urandom_range(0, 3));
            v.data = $urandom; v.width = 2'($urandom); v.noise = $urandom;
            v.done_off = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, TO - 3)) : -1;
            v.dout = $urandom; v.nerr = 2'($urandom);
            v.rdy_dly = $urandom_range(0, 4);
            v.resp_pulse = 1'($urandom);
            run_txn(model(v));
        end

        // Reset during CTRL SETUP (cycle 7) discards the command.
        cmd_valid = 1'b1; cmd_ctrl = 2'd1; cmd_data = 32'h77; cmd_width = 2'd2; cmd_noise = 32'h3;
        step();
        cmd_valid = 1'b0;
        for (int k = 1; k < 7; k++) step();
        chk("ctrl_setup", {42'd0, PSEL, PENABLE, PADDR}, {42'd0, 1'b1, 1'b0, 20'h0});
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_ctl", {60'd0, PSEL, cmd_ready, rsp_valid, rsp_illegal}, 64'h4);
        chk("rst_mid_rsp", {29'd0, rsp_data, rsp_errors, rsp_timeout}, 64'd0);
        for (int k = 0; k < 6; k++) begin
            operation_done = (k == 2); data_out = 32'hBEEF; num_of_errors = 2'd2;
            step();
            chk("rst_no_rsp", {62'd0, rsp_valid, cmd_ready}, 64'd1);
        end
        operation_done = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ecc_apb_driver.md
ECC_APB_DRIVER -- requirements
Module: ecc_apb_driver

Interface
REQ-001 Parameters SHALL be: AMBA_WORD, 32, APB data width; AMBA_ADDR_WIDTH, 20, APB address width; DATA_WIDTH, 32, ECC data width; TIMEOUT, 1000, maximum cycles to wait for operation_done.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be, one per line (name direction width meaning):
 clk  in  1  clock, rising edge
 rst  in  1  synchronous active-high reset
 cmd_valid  in  1  command offered
 cmd_ready  out  1  command accepted when high with cmd_valid
 cmd_ctrl  in  2  operation: 0 encode, 1 decode, 2 full, 3 illegal
 cmd_data  in  DATA_WIDTH  data/codeword to process
 cmd_width  in  2  CODEWORD_WIDTH register value
 cmd_noise  in  DATA_WIDTH  NOISE register value
 PADDR  out  AMBA_ADDR_WIDTH  APB address
 PSEL  out  1  APB select
 PENABLE  out  1  APB enable
 PWRITE  out  1  APB write
 PWDATA  out  AMBA_WORD  APB write data
 data_out  in  DATA_WIDTH  ECC result
 operation_done  in  1  ECC result valid, one-cycle pulse
 num_of_errors  in  2  ECC error count
 rsp_valid  out  1  response available
 rsp_ready  in  1  response consumed when high with rsp_valid
 rsp_data  out  DATA_WIDTH  captured data_out
 rsp_errors  out  2  captured num_of_errors
 rsp_timeout  out  1  no operation_done within TIMEOUT
 rsp_illegal  out  1  command rejected, cmd_ctrl==3

Function
REQ-004 FSM states SHALL be IDLE, SETUP, ACCESS, WAIT, RESP.
REQ-005 cmd_ready SHALL be 1 only in IDLE; on cmd_valid&cmd_ready all cmd_* fields are latched.
REQ-006 Accepted cmd_ctrl 0..2: IDLE->SETUP, register index=0; cmd_ctrl 3: IDLE->RESP with rsp_illegal=1, rsp_data=0, rsp_errors=0, no APB traffic.
REQ-007 Writes SHALL be issued in fixed order: index 0 DATA_IN 0x04, 1 CODEWORD_WIDTH 0x08, 2 NOISE 0x0C, 3 CTRL 0x00; CTRL is always last.
REQ-008 SETUP: PSEL=1, PENABLE=0; ACCESS: PSEL=1, PENABLE=1; each transfer exactly 2 cycles (no wait states); PADDR, PWDATA, PWRITE=1 stable across both cycles.
REQ-009 PWDATA for CODEWORD_WIDTH and CTRL SHALL be the 2-bit value zero-extended to AMBA_WORD.
REQ-010 ACCESS with index<3: ->SETUP, index+1; ACCESS with index==3: ->WAIT, timeout counter cleared.
REQ-011 Outside SETUP/ACCESS: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0.
REQ-012 operation_done SHALL be ignored in every state except WAIT.
REQ-013 WAIT with operation_done=1: capture data_out, num_of_errors; ->RESP, rsp_timeout=0.
REQ-014 WAIT counter increments every cycle without operation_done; reaching TIMEOUT-1 ->RESP, rsp_timeout=1, rsp_data=0, rsp_errors=0; counter SHALL not wrap.
REQ-015 RESP: rsp_valid=1, rsp_* held stable until rsp_ready=1; then ->IDLE, rsp_valid=0 next cycle.
REQ-016 Latency: handshake at cycle 0; DATA_IN SETUP cycle 1; CTRL ACCESS cycle 8; WAIT from cycle 9; rsp_valid the cycle after operation_done is sampled.
REQ-017 A new command SHALL not be accepted in the cycle rsp_ready completes RESP (cmd_ready rises one cycle later).

Reset
REQ-018 rst=1 SHALL force IDLE on the next edge regardless of state, including mid-transfer: cmd_ready=1, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_data=0, rsp_errors=0, rsp_timeout=0, rsp_illegal=0, counters=0.
REQ-019 A command in flight at reset SHALL be discarded with no response.

Verification
REQ-020 Encode: cmd_ctrl=0, cmd_data=0x0000_00A5, cmd_width=0, cmd_noise=0 -> writes 0x04/0xA5, 0x08/0, 0x0C/0, 0x00/0 on cycles 1-8; done at cycle 12 with data_out=0x1A5 -> rsp_valid cycle 13, rsp_data=0x1A5.
REQ-021 Decode with noise=0x0000_0001, num_of_errors=1 -> rsp_errors=1, rsp_timeout=0.
REQ-022 TIMEOUT=16, operation_done never asserted -> rsp_timeout=1, rsp_data=0 at cycle 9+16.
REQ-023 cmd_ctrl=3 -> PSEL never high, rsp_illegal=1 on cycle 1.
REQ-024 rst asserted during CTRL SETUP -> next cycle PSEL=0, cmd_ready=1; later operation_done pulse produces no response.
REQ-025 rsp_ready held 0 for 10 cycles -> rsp_* stable, cmd_ready=0; operation_done pulse during RESP ignored.
